// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle sequencer for CHIP-8 8XYN ALU opcodes.
// It reads VX and VY through a single synchronous register-file read port,
// drives an external combinational ALU, and writes back VX and then VF.
// Optional build macro: CHIP8_VF_RESET_EN. When defined, OR/AND/XOR also
// clear VF (COSMAC behaviour).
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        ready,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  rf_raddr,
  input  logic [7:0]  rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [7:0]  rf_wdata,
  output logic [7:0]  alu_x,
  output logic [7:0]  alu_y,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ERR,
    S_RD_X,
    S_RD_Y,
    S_LAT_Y,
    S_EXEC,
    S_WB_X,
    S_WB_F,
    S_DONE
  } state_t;

  state_t     state;
  logic [3:0] x_q;
  logic [3:0] y_q;
  logic [2:0] op_q;
  logic       swap_q;
  logic       wrf_q;
  logic [7:0] op_a;
  logic       flg;

  logic       dec_legal;
  logic [2:0] dec_op;
  logic       dec_swap;
  logic       dec_wrf;
  logic       flag_calc;

`ifdef CHIP8_VF_RESET_EN
  localparam logic LOGIC_WRF = 1'b1;
`else
  localparam logic LOGIC_WRF = 1'b0;
`endif

  // Decode the incoming opcode: legality, ALU op, operand swap, flag write.
  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 3'd0;
    dec_swap  = 1'b0;
    dec_wrf   = 1'b0;
    if (opcode[15:12] == 4'h8) begin
      case (opcode[3:0])
        4'h0: begin dec_legal = 1'b1; dec_op = 3'd0; end
        4'h1: begin dec_legal = 1'b1; dec_op = 3'd1; dec_wrf = LOGIC_WRF; end
        4'h2: begin dec_legal = 1'b1; dec_op = 3'd2; dec_wrf = LOGIC_WRF; end
        4'h3: begin dec_legal = 1'b1; dec_op = 3'd3; dec_wrf = LOGIC_WRF; end
        4'h4: begin dec_legal = 1'b1; dec_op = 3'd4; dec_wrf = 1'b1; end
        4'h5: begin dec_legal = 1'b1; dec_op = 3'd5; dec_wrf = 1'b1; end
        4'h6: begin dec_legal = 1'b1; dec_op = 3'd6; dec_wrf = 1'b1; end
        4'h7: begin dec_legal = 1'b1; dec_op = 3'd5; dec_wrf = 1'b1; dec_swap = 1'b1; end
        4'hE: begin dec_legal = 1'b1; dec_op = 3'd7; dec_wrf = 1'b1; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Flag for the op in EXEC; alu_x is always the minuend for SUB/SUBN.
  always_comb begin
    flag_calc = 1'b0;
    case (op_q)
      3'd4, 3'd6, 3'd7: flag_calc = alu_carry;
      3'd5:             flag_calc = (alu_x >= alu_y);
      default:          flag_calc = 1'b0;
    endcase
  end

  // Sequencer FSM; every output is registered and computed for the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      illegal  <= 1'b0;
      rf_raddr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      alu_x    <= '0;
      alu_y    <= '0;
      alu_op   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= '0;
      swap_q   <= 1'b0;
      wrf_q    <= 1'b0;
      op_a     <= '0;
      flg      <= 1'b0;
    end else begin
      ready    <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      rf_raddr <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      alu_x    <= '0;
      alu_y    <= '0;
      alu_op   <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q    <= opcode[11:8];
            y_q    <= opcode[7:4];
            op_q   <= dec_op;
            swap_q <= dec_swap;
            wrf_q  <= dec_wrf;
            if (dec_legal) begin
              state    <= S_RD_X;
              rf_raddr <= opcode[11:8];
            end else begin
              state   <= S_ERR;
              illegal <= 1'b1;
            end
          end else begin
            ready <= 1'b1;
          end
        end
        S_ERR: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        S_RD_X: begin
          state    <= S_RD_Y;
          rf_raddr <= y_q;
        end
        S_RD_Y: begin
          state <= S_LAT_Y;
          op_a  <= rf_rdata;
        end
        // VY arrives here and is loaded straight into the ALU operand
        // registers, which serve as opB.
        S_LAT_Y: begin
          state  <= S_EXEC;
          alu_x  <= swap_q ? rf_rdata : op_a;
          alu_y  <= swap_q ? op_a : rf_rdata;
          alu_op <= op_q;
        end
        S_EXEC: begin
          state    <= S_WB_X;
          flg      <= flag_calc;
          rf_we    <= 1'b1;
          rf_waddr <= x_q;
          rf_wdata <= alu_out;
        end
        S_WB_X: begin
          if (wrf_q) begin
            state    <= S_WB_F;
            rf_we    <= 1'b1;
            rf_waddr <= 4'hF;
            rf_wdata <= {7'b0, flg};
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_WB_F: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random 8XYN opcodes checked against an
// arithmetic reference model; the bench provides the register file and ALU.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] opcode;
  logic        ready, done, illegal;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [7:0]  rf_rdata, rf_wdata;
  logic        rf_we;
  logic [7:0]  alu_x, alu_y, alu_out;
  logic [2:0]  alu_op;
  logic        alu_carry;

  logic        tb_we;
  logic [3:0]  tb_waddr;
  logic [7:0]  tb_wdata;
  logic [7:0]  rf [16];
  logic [7:0]  model_v [16];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

`ifdef CHIP8_VF_RESET_EN
  localparam bit VF_RESET = 1'b1;
`else
  localparam bit VF_RESET = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .ready(ready), .done(done), .illegal(illegal),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  // Register file with one synchronous read port.
  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (tb_we) rf[tb_waddr] <= tb_wdata;
  end

  // ALU; SUB drives the borrow on carry so a design trusting it is caught.
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b1;
    case (alu_op)
      3'd0: alu_out = alu_y;
      3'd1: alu_out = alu_x | alu_y;
      3'd2: alu_out = alu_x & alu_y;
      3'd3: alu_out = alu_x ^ alu_y;
      3'd4: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
      3'd5: begin alu_out = alu_x - alu_y; alu_carry = (alu_x < alu_y); end
      3'd6: begin alu_out = alu_x >> 1; alu_carry = alu_x[0]; end
      default: begin alu_out = alu_x << 1; alu_carry = alu_x[7]; end
    endcase
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    model_v[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue one opcode and compare its whole life against the model.
  // poke: re-assert start with another opcode in cycle 3 (must be ignored).
  // rst_at: assert rst during that cycle (0 = never).
  task automatic run_op(input logic [15:0] op, input bit poke, input int rst_at);
    logic [3:0] x, y, n;
    logic [7:0] vx, vy, res, ex_x, ex_y;
    logic [8:0] sum;
    logic [2:0] ex_op;
    bit legal, wrf, f;
    int done_cyc, ill_cyc, rdy_cyc, we_cnt, done_cnt, wait_cnt;
    x = op[11:8]; y = op[7:4]; n = op[3:0];
    vx = model_v[x]; vy = model_v[y];
    legal = (op[15:12] == 4'h8) && (n <= 4'h7 || n == 4'hE);
    res = 8'h00; wrf = 1'b0; f = 1'b0;
    ex_x = vx; ex_y = vy; ex_op = n[2:0];
    case (n)
      4'h0: res = vy;
      4'h1: begin res = vx | vy; wrf = VF_RESET; end
      4'h2: begin res = vx & vy; wrf = VF_RESET; end
      4'h3: begin res = vx ^ vy; wrf = VF_RESET; end
      4'h4: begin sum = vx + vy; res = sum[7:0]; f = sum[8]; wrf = 1'b1; end
      4'h5: begin res = vx - vy; f = (vx >= vy); wrf = 1'b1; end
      4'h6: begin res = vx >> 1; f = vx[0]; wrf = 1'b1; end
      4'h7: begin res = vy - vx; f = (vy >= vx); wrf = 1'b1;
                  ex_x = vy; ex_y = vx; ex_op = 3'd5; end
      4'hE: begin res = vx << 1; f = vx[7]; wrf = 1'b1; ex_op = 3'd7; end
      default: ;
    endcase

    wait_cnt = 0;
    while (!ready && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
    if (!ready) check_eq("ready_before_start", {15'd0, ready}, 16'd1);

    start = 1'b1; opcode = op;
    @(negedge clk);
    start = 1'b0;
    done_cyc = 0; ill_cyc = 0; rdy_cyc = 0; we_cnt = 0; done_cnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = cyc; end
      if (illegal && ill_cyc == 0) ill_cyc = cyc;
      if (rf_we) we_cnt++;
      if (legal && rst_at == 0) begin
        if (cyc == 1) check_eq("raddr_x", {12'd0, rf_raddr}, {12'd0, x});
        if (cyc == 2) check_eq("raddr_y", {12'd0, rf_raddr}, {12'd0, y});
        if (cyc == 4) begin
          check_eq("alu_op", {13'd0, alu_op}, {13'd0, ex_op});
          check_eq("alu_xy", {alu_x, alu_y}, {ex_x, ex_y});
        end
      end
      if (poke && cyc == 3) begin start = 1'b1; opcode = 16'h8235; end
      else start = 1'b0;
      if (cyc == rst_at) begin
        check_eq("we_in_wbx", {15'd0, rf_we}, 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_ready", {15'd0, ready}, 16'd1);
        check_eq("rst_we", {15'd0, rf_we}, 16'd0);
        check_eq("rst_done", {15'd0, done}, 16'd0);
        rdy_cyc = cyc + 1;
        break;
      end
      if (ready) begin rdy_cyc = cyc; break; end
      @(negedge clk);
    end

    if (rst_at != 0) begin
      model_v[x] = res;
    end else if (legal) begin
      check_eq("done_cycle", 16'(done_cyc), wrf ? 16'd7 : 16'd6);
      check_eq("done_pulses", 16'(done_cnt), 16'd1);
      check_eq("ready_cycle", 16'(rdy_cyc), wrf ? 16'd8 : 16'd7);
      check_eq("we_count", 16'(we_cnt), wrf ? 16'd2 : 16'd1);
      check_eq("no_illegal", 16'(ill_cyc), 16'd0);
      model_v[x] = res;
      if (wrf) model_v[15] = {7'd0, f};
    end else begin
      check_eq("illegal_cycle", 16'(ill_cyc), 16'd1);
      check_eq("ready_cycle", 16'(rdy_cyc), 16'd2);
      check_eq("we_count", 16'(we_cnt), 16'd0);
      check_eq("no_done", 16'(done_cnt), 16'd0);
    end

    // Idle window: no stray write or completion (covers ignored start).
    we_cnt = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (rf_we) we_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    check_eq("idle_quiet", 16'(we_cnt + done_cnt), 16'd0);
    check_eq("vx", {8'd0, rf[x]}, {8'd0, model_v[x]});
    check_eq("vf", {8'd0, rf[15]}, {8'd0, model_v[15]});
    if (poke) check_eq("v2_untouched", {8'd0, rf[2]}, {8'd0, model_v[2]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rx, ry, rn, rh;
    rst = 1'b1; start = 1'b0; opcode = 16'h0000;
    tb_we = 1'b0; tb_waddr = 4'h0; tb_wdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", {15'd0, ready}, 16'd1);
    check_eq("rst_flags", {13'd0, done, illegal, rf_we}, 16'd0);
    check_eq("rst_addr", {4'd0, rf_raddr, rf_waddr, 4'd0}, 16'd0);
    check_eq("rst_wdata", {8'd0, rf_wdata}, 16'd0);
    check_eq("rst_alu", {alu_x, alu_y}, 16'd0);
    check_eq("rst_aluop", {13'd0, alu_op}, 16'd0);

    for (int i = 0; i < 16; i++) set_reg(4'(i), 8'(i * 17));

    set_reg(4'h1, 8'hF0); set_reg(4'h2, 8'h20); run_op(16'h8124, 1'b0, 0);
    set_reg(4'h1, 8'hF0); set_reg(4'h2, 8'h0F); run_op(16'h8124, 1'b1, 0);
    set_reg(4'h1, 8'h30); set_reg(4'h2, 8'h30); run_op(16'h8125, 1'b0, 0);
    set_reg(4'h1, 8'h40); set_reg(4'h2, 8'h10); run_op(16'h8127, 1'b0, 0);
    set_reg(4'hF, 8'h81); run_op(16'h8F06, 1'b0, 0);
    set_reg(4'h1, 8'h81); run_op(16'h810E, 1'b0, 0);
    set_reg(4'h1, 8'h0C); set_reg(4'h2, 8'h03); set_reg(4'hF, 8'h55);
    run_op(16'h8121, 1'b0, 0);
    set_reg(4'h3, 8'hA5); run_op(16'h8334, 1'b0, 0);
    run_op(16'h8128, 1'b0, 0);
    run_op(16'h9120, 1'b0, 0);
    set_reg(4'h1, 8'hF0); set_reg(4'h2, 8'h20); set_reg(4'hF, 8'h33);
    run_op(16'h8124, 1'b0, 5);

    for (int i = 0; i < 40; i++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      rn = 4'($urandom_range(0, 15));
      rh = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h8;
      set_reg(rx, 8'($urandom));
      set_reg(ry, 8'($urandom));
      if (rx != 4'hF && ry != 4'hF) set_reg(4'hF, 8'($urandom));
      run_op({rh, rx, ry, rn}, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle sequencer for CHIP-8 arithmetic/logic opcodes (8XYN). It accepts an opcode from the instruction decoder through a start/ready handshake. It then fetches VX and VY from the V-register file through its single synchronous read port, and drives the combinational ALU with them. Finally it writes the result back to VX and the flag to VF in separate cycles.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only on a rising clk edge where ready=1.
- opcode  in  16  8XYN instruction; sampled when start is accepted.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when an accepted legal opcode completes.
- illegal  out  1  one-cycle pulse when the accepted opcode is not a legal 8XYN opcode.
- rf_raddr  out  4  register-file read address.
- rf_rdata  in  8  register-file read data; valid one cycle after rf_raddr.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  4  register-file write address.
- rf_wdata  out  8  register-file write data.
- alu_x  out  8  ALU X operand.
- alu_y  out  8  ALU Y operand.
- alu_op  out  3  ALU operation: 0 Y, 1 OR, 2 AND, 3 XOR, 4 ADD, 5 SUB, 6 SHR, 7 SHL.
- alu_out  in  8  ALU result.
- alu_carry  in  1  ALU carry/shifted-out bit.

## Operation
Decoding of N:
- 0→op0, 1→op1, 2→op2, 3→op3, 4→op4, 5→op5, 6→op6, E→op7.
- 7 (SUBN, VY−VX) uses op5 with operands swapped: alu_x=VY, alu_y=VX.
- Legal: opcode[15:12]=8 and N ∈ {0–7, E}. Anything else is illegal.

An illegal opcode produces no register reads or writes. illegal pulses in the cycle after acceptance, and the sequencer returns to IDLE.

States (all other transitions are unconditional to the next state):
- IDLE: ready=1.
  - On start: latch X, Y and N.
  - Go to ERR if illegal, otherwise RD_X.
- ERR: illegal=1. Go to IDLE.
- RD_X: rf_raddr=X.
- RD_Y: rf_raddr=Y; latch rf_rdata into opA (VX).
- LAT_Y: latch rf_rdata into opB (VY).
- EXEC: alu_x/alu_y/alu_op are driven from the latched operands; register alu_out into res and the flag into flg.
- WB_X: rf_we=1, rf_waddr=X, rf_wdata=res. Go to WB_F if the op writes a flag, otherwise DONE.
- WB_F: rf_we=1, rf_waddr=F, rf_wdata={7'b0,flg}.
- DONE: done=1. Go to IDLE.

Flag rules:
- ADD: flg=alu_carry (carry out of the 9-bit sum).
- SUB/SUBN: flg = (minuend ≥ subtrahend), computed locally in 8-bit unsigned arithmetic; alu_carry is ignored. Equal operands give flg=1.
- SHR: flg=alu_carry (old bit 0).
- SHL: flg=alu_carry (old bit 7).
- Op0–op3: see Configuration.

Results are truncated to 8 bits (wrap-around).

Boundary conditions:
- X=F: VX is written first, then VF is written with the flag, so the flag wins.
- X=Y: reads the same register twice; legal.
- start while busy: ignored, not queued.
- rst in any state: IDLE next cycle, rf_we=0 from that edge. Writes already committed stay; no further writes occur.

## Timing
Reset values, and values outside the states that drive them:
- done=0, illegal=0, rf_we=0.
- rf_raddr=0, rf_waddr=0, rf_wdata=0.
- alu_x=0, alu_y=0, alu_op=0.
- ready=1 in the first cycle after the reset edge.

Latency, with start accepted at edge 0:
- RD_X occupies cycle 1, EXEC cycle 4, WB_X cycle 5.
- With a flag write: WB_F cycle 6, done cycle 7, ready again cycle 8.
- Without a flag write: done cycle 6, ready again cycle 7.
- Illegal opcode: illegal in cycle 1, ready in cycle 2.

Register-file writes take effect at the end of the cycle in which rf_we is high.

## Configuration
- CHIP8_VF_RESET_EN defined: op1/op2/op3 (OR/AND/XOR) write VF=0 in WB_F, matching COSMAC behaviour; done arrives in cycle 7.
- CHIP8_VF_RESET_EN undefined: op1–op3 skip WB_F and leave VF untouched; done arrives in cycle 6.
- Op0 (LD) never writes VF in either build.

## Test plan
- 8124 with V1=0xF0, V2=0x20 → V1=0x10, VF=1, done in cycle 7. Repeat with V2=0x0F → V1=0xFF, VF=0.
- 8125 with V1=0x30, V2=0x30 → V1=0x00, VF=1. 8127 with V1=0x40, V2=0x10 → V1=0xD0, VF=0.
- 8F06 with VF=0x81 → VF=0x01: result 0x40 is overwritten by flag=1. 810E with V1=0x81 → V1=0x02, VF=1.
- 8121 with V1=0x0C, V2=0x03, VF=0x55:
  - With CHIP8_VF_RESET_EN: V1=0x0F, VF=0, done in cycle 7.
  - Without it: VF=0x55, done in cycle 6.
- 8128 and 9120 → illegal pulses in cycle 1, rf_we never asserted, ready=1 in cycle 2.
- Assert rst during WB_X of 8124:
  - Next cycle: IDLE, ready=1, no VF write.
  - start asserted in cycle 3 is ignored while busy: no second operation.
